// File: rtl/fib_stream_checker.sv
// rtl/fib_stream_checker.sv - consumer that requests Fibonacci terms and checks each against the recurrence
module fib_stream_checker #(
  parameter int          CW          = 16,
  parameter int          TIMEOUT     = 64,
  parameter int          STRICT_SEED = 1,
  parameter logic [15:0] SEED0       = 16'd0,
  parameter logic [15:0] SEED1       = 16'd1,
  parameter int          CHK_OVF     = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] n_terms,
  input  logic          f_valid,
  input  logic [15:0]   f_out,
  output logic          f_en,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [1:0]    err_code,
  output logic [CW-1:0] term_cnt,
  output logic [15:0]   exp_term,
  output logic [15:0]   got_term
);

  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE, FAIL} state_t;

  state_t        state, state_n;
  logic [CW-1:0] n_lat, n_lat_n, term_cnt_n;
  logic [15:0]   a, a_n, b, b_n, exp_n, got_n;
  logic [WW-1:0] wait_cnt, wait_n;
  logic [1:0]    err_n;
  logic [16:0]   sum;
  logic [15:0]   exp_v;
  logic          bad, ovf;

  always_comb begin
    state_n    = state;
    n_lat_n    = n_lat;
    term_cnt_n = term_cnt;
    a_n        = a;
    b_n        = b;
    wait_n     = wait_cnt;
    err_n      = err_code;
    exp_n      = exp_term;
    got_n      = got_term;
    sum        = {1'b0, a} + {1'b0, b};
    exp_v      = sum[15:0];
    bad        = 1'b0;
    ovf        = 1'b0;

    // Expected value for the term index held in term_cnt; unchecked seeds expect themselves
    if (term_cnt == '0) begin
      exp_v = (STRICT_SEED != 0) ? SEED0 : f_out;
    end else if (term_cnt == CW'(1)) begin
      exp_v = (STRICT_SEED != 0) ? SEED1 : f_out;
    end else begin
      ovf = (CHK_OVF != 0) && sum[16];
    end
    bad = (f_out != exp_v);

    case (state)
      RUN: begin
        if (f_valid) begin
          exp_n = exp_v;
          got_n = f_out;
          if (ovf) begin
            state_n = FAIL;
            err_n   = 2'b11;
          end else if (bad) begin
            state_n = FAIL;
            err_n   = 2'b01;
          end else begin
            term_cnt_n = term_cnt + CW'(1);
            wait_n     = '0;
            if (term_cnt == '0) begin
              a_n = f_out;
            end else if (term_cnt == CW'(1)) begin
              b_n = f_out;
            end else begin
              a_n = b;
              b_n = f_out;
            end
            if (term_cnt + CW'(1) == n_lat) state_n = DONE;
          end
        end else begin
          wait_n = wait_cnt + WW'(1);
          if (wait_cnt == WW'(TIMEOUT - 1)) begin
            state_n = FAIL;
            err_n   = 2'b10;
          end
        end
      end
      default: begin
        if (start) begin
          term_cnt_n = '0;
          err_n      = 2'b00;
          wait_n     = '0;
          a_n        = '0;
          b_n        = '0;
          n_lat_n    = n_terms;
          state_n    = (n_terms == '0) ? DONE : RUN;
        end
      end
    endcase
  end

  // Status flags are decoded from the next state so they are true flops aligned with state
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      n_lat    <= '0;
      term_cnt <= '0;
      a        <= '0;
      b        <= '0;
      wait_cnt <= '0;
      err_code <= 2'b00;
      exp_term <= '0;
      got_term <= '0;
      f_en     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      state    <= state_n;
      n_lat    <= n_lat_n;
      term_cnt <= term_cnt_n;
      a        <= a_n;
      b        <= b_n;
      wait_cnt <= wait_n;
      err_code <= err_n;
      exp_term <= exp_n;
      got_term <= got_n;
      f_en     <= (state_n == RUN);
      busy     <= (state_n == RUN);
      done     <= (state_n == DONE);
      error    <= (state_n == FAIL);
    end
  end

endmodule
